// File: rtl/iter_mul_div_pkg.sv
// Shared op encodings and FSM state type for the iterative multiply/divide unit.
package iter_mul_div_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide on magnitudes.
module mdu_step
    import iter_mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, m_i} : '0);
        shifted = {acc_i, mq_i[WIDTH-1]};
        diff    = shifted - {1'b0, m_i};
        if (is_div_i) begin
            // diff[WIDTH] is the borrow: set means the partial remainder stays
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_mul_div.sv
// Iterative signed/unsigned multiplier and divider: one bit per cycle, sign fix-up at the end.
module iter_mul_div
    import iter_mul_div_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIV_EN = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               dz_q, dz_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               res_dz_q, res_dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_div_c;
    logic               op_signed_c;
    logic               a_neg_c;
    logic               b_neg_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [WIDTH-1:0]   step_acc_c;
    logic [WIDTH-1:0]   step_mq_c;
    logic [2*WIDTH-1:0] prod_neg_c;

    assign op_div_c    = (DIV_EN != 0) && ((op == OP_DIV) || (op == OP_DIVU));
    assign op_signed_c = !((op == OP_MULU) || (op == OP_DIVU));
    assign a_neg_c     = op_signed_c & a[WIDTH-1];
    assign b_neg_c     = op_signed_c & b[WIDTH-1];
    assign a_mag_c     = a_neg_c ? WIDTH'(-a) : a;
    assign b_mag_c     = b_neg_c ? WIDTH'(-b) : b;
    assign prod_neg_c  = -{acc_q, mq_q};

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .mq_i     (mq_q),
        .m_i      (m_q),
        .acc_o    (step_acc_c),
        .mq_o     (step_mq_c)
    );

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        hold_d   = hold_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_dz_d = res_dz_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_div_c;
                    neg_a_d  = a_neg_c;
                    neg_b_d  = b_neg_c;
                    acc_d    = '0;
                    mq_d     = a_mag_c;
                    m_d      = b_mag_c;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    dz_d     = 1'b0;
                    hold_d   = 1'b0;
                    state_d  = RUN;
                    if (op_div_c && (b == '0)) begin
                        acc_d   = a;
                        mq_d    = '1;
                        dz_d    = 1'b1;
                        hold_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                acc_d = step_acc_c;
                mq_d  = step_mq_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Quotient takes the xor of signs, remainder follows the dividend
                if (is_div_q) begin
                    if (neg_a_q ^ neg_b_q) begin
                        mq_d = -mq_q;
                    end
                    if (neg_a_q) begin
                        acc_d = -acc_q;
                    end
                end else if (neg_a_q ^ neg_b_q) begin
                    {acc_d, mq_d} = prod_neg_c;
                end
                state_d = DONE;
            end
            DONE: begin
                // Divide by zero dwells one extra cycle here so done lands two cycles after accept
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    hi_d     = acc_q;
                    lo_d     = mq_q;
                    res_dz_d = dz_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
    end

    // State and output registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mq_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_dz_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_dz_q <= res_dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = res_dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
